// File: rtl/jambu_perm_inv.sv
// TinyJAMBU keyed permutation run backwards: undoes N 32-round steps,
// one step per clock, with a valid/ready request and response handshake.
module jambu_perm_inv (
    input  logic         g_clk,
    input  logic         g_resetn,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_state,
    input  logic [127:0] req_key,
    input  logic [5:0]   req_steps,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_state,
    output logic         busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]   fsm;
    logic [5:0]   cnt;
    logic [127:0] work;
    logic [127:0] key;
    logic [31:0]  key_w;
    logic [127:0] work_prev;

    // Undo one forward step: the newest word a3 is the forward feedback, so
    // XOR-ing the same nonlinear terms back out recovers the dropped s0.
    function automatic logic [127:0] inv_step(input logic [127:0] a, input logic [31:0] k);
        logic [31:0] a0, a1, a2, a3;
        logic [31:0] t1, t2, t3, t4, s0;
        a0 = a[31:0];
        a1 = a[63:32];
        a2 = a[95:64];
        a3 = a[127:96];
        t1 = 32'({a1, a0} >> 15);
        t2 = 32'({a2, a1} >> 6);
        t3 = 32'({a2, a1} >> 21);
        t4 = 32'({a2, a1} >> 27);
        s0 = a3 ^ t1 ^ ~(t2 & t3) ^ t4 ^ k;
        return {a2, a1, a0, s0};
    endfunction

    // The down-counter is the step index j, so its low bits pick the key word.
    assign key_w     = key[{cnt[1:0], 5'd0} +: 32];
    assign work_prev = inv_step(work, key_w);

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            fsm  <= S_IDLE;
            cnt  <= 6'd0;
            work <= 128'd0;
            key  <= 128'd0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (req_valid) begin
                        work <= req_state;
                        key  <= req_key;
                        cnt  <= req_steps - 6'd1;
                        fsm  <= (req_steps == 6'd0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    work <= work_prev;
                    cnt  <= cnt - 6'd1;
                    if (cnt == 6'd0)
                        fsm <= S_DONE;
                end
                S_DONE: begin
                    if (rsp_ready)
                        fsm <= S_IDLE;
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (fsm == S_IDLE);
    assign busy      = (fsm != S_IDLE);
    assign rsp_valid = (fsm == S_DONE);
    assign rsp_state = work;

endmodule

// File: tb/tb_jambu_perm_inv.sv
// Bench for jambu_perm_inv: fixed vectors, forward-model round trips,
// backpressure, input isolation and mid-run reset.
module tb_jambu_perm_inv;

    logic         g_clk;
    logic         g_resetn;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_state;
    logic [127:0] req_key;
    logic [5:0]   req_steps;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_state;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    jambu_perm_inv dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_state (req_state),
        .req_key   (req_key),
        .req_steps (req_steps),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_state (rsp_state),
        .busy      (busy)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    typedef struct {
        logic [127:0] st;
        logic [127:0] key;
        logic [5:0]   n;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] RT_KEY = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

    // Forward TinyJAMBU steps on a plain word array, step j using key word j mod 4.
    function automatic logic [127:0] fwd(input logic [127:0] st, input logic [127:0] key, input int n);
        logic [31:0] s [4];
        logic [31:0] k [4];
        logic [31:0] t1, t2, t3, t4, fb;
        for (int i = 0; i < 4; i++) begin
            s[i] = st[32*i +: 32];
            k[i] = key[32*i +: 32];
        end
        for (int j = 0; j < n; j++) begin
            t1 = 32'({s[2], s[1]} >> 15);
            t2 = 32'({s[3], s[2]} >> 6);
            t3 = 32'({s[3], s[2]} >> 21);
            t4 = 32'({s[3], s[2]} >> 27);
            fb = s[0] ^ t1 ^ ~(t2 & t3) ^ t4 ^ k[j % 4];
            s[0] = s[1];
            s[1] = s[2];
            s[2] = s[3];
            s[3] = fb;
        end
        return {s[3], s[2], s[1], s[0]};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request and consume its response after bp stall cycles.
    task automatic do_req(input logic [127:0] st, input logic [127:0] key, input logic [5:0] n,
                          input int bp, input bit scramble,
                          output logic [127:0] res, output int lat);
        int guard;
        @(negedge g_clk);
        req_state = st;
        req_key   = key;
        req_steps = n;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge g_clk);
            guard++;
        end
        chk("req_ready_wait", {127'd0, req_ready}, 128'd1);
        @(posedge g_clk);
        @(negedge g_clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            chk("busy_xor_ready", {127'd0, busy ^ req_ready}, 128'd1);
            if (scramble) begin
                req_state = rnd128();
                req_key   = rnd128();
                req_steps = 6'($urandom);
            end
            @(negedge g_clk);
            lat++;
        end
        chk("rsp_valid_seen", {127'd0, rsp_valid}, 128'd1);
        res = rsp_state;
        for (int i = 0; i < bp; i++) begin
            @(negedge g_clk);
            chk("bp_valid", {127'd0, rsp_valid}, 128'd1);
            chk("bp_state", rsp_state, res);
            chk("bp_ready_low", {127'd0, req_ready}, 128'd0);
        end
        rsp_ready = 1'b1;
        @(posedge g_clk);
        #1;
        rsp_ready = 1'b0;
        chk("consume_valid_low", {127'd0, rsp_valid}, 128'd0);
        chk("consume_ready_high", {127'd0, req_ready}, 128'd1);
    endtask

    initial begin
        vec_t         vecs [5];
        logic [127:0] res, x, key;
        int           lat;
        logic [5:0]   n;
        int           rt_n [3];

        vecs[0] = '{128'hFFFFFFFF_00000000_00000000_00000000, 128'd0, 6'd1, 128'd0};
        vecs[1] = '{128'h01234567_89ABCDEF_01234567_89ABCDEF, 128'h55, 6'd0,
                    128'h01234567_89ABCDEF_01234567_89ABCDEF};
        vecs[2] = '{128'hFFFFFFFF_00000000_00000000_00000000, 128'h0_FFFFFFFF, 6'd1,
                    128'h00000000_00000000_00000000_FFFFFFFF};
        vecs[3] = '{128'd0, 128'd0, 6'd1, 128'h00000000_00000000_00000000_FFFFFFFF};
        vecs[4] = '{128'd0, 128'hFFFFFFFF, 6'd1, 128'd0};
        rt_n = '{20, 32, 40};

        g_resetn  = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_state = '0;
        req_key   = '0;
        req_steps = '0;
        #1;
        chk("reset_rsp_valid", {127'd0, rsp_valid}, 128'd0);
        chk("reset_busy", {127'd0, busy}, 128'd0);
        chk("reset_rsp_state", rsp_state, 128'd0);
        repeat (2) @(negedge g_clk);
        g_resetn = 1'b1;
        @(posedge g_clk);
        #1;
        chk("post_reset_ready", {127'd0, req_ready}, 128'd1);

        for (int i = 0; i < 5; i++) begin
            do_req(vecs[i].st, vecs[i].key, vecs[i].n, 0, 1'b0, res, lat);
            chk($sformatf("vec%0d_state", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(int'(vecs[i].n) + 1));
        end

        // Round trips with the reference key; the N=20 one also scrambles inputs mid-run.
        for (int i = 0; i < 3; i++) begin
            x = rnd128();
            do_req(fwd(x, RT_KEY, rt_n[i]), RT_KEY, 6'(rt_n[i]), 0, 1'b0, res, lat);
            chk($sformatf("rt%0d_state", rt_n[i]), res, x);
            chk($sformatf("rt%0d_latency", rt_n[i]), 128'(lat), 128'(rt_n[i] + 1));
        end
        x = rnd128();
        do_req(fwd(x, RT_KEY, 20), RT_KEY, 6'd20, 0, 1'b1, res, lat);
        chk("isolation_state", res, x);
        chk("isolation_latency", 128'(lat), 128'd21);

        do_req(fwd(x, RT_KEY, 3), RT_KEY, 6'd3, 5, 1'b0, res, lat);
        chk("backpressure_state", res, x);

        for (int i = 0; i < 12; i++) begin
            x   = rnd128();
            key = rnd128();
            n   = 6'($urandom_range(0, 63));
            do_req(fwd(x, key, int'(n)), key, n, int'($urandom_range(0, 3)), 1'b0, res, lat);
            chk($sformatf("rand%0d_state", i), res, x);
            chk($sformatf("rand%0d_latency", i), 128'(lat), 128'(int'(n) + 1));
        end

        // Reset partway through an N=20 run.
        @(negedge g_clk);
        req_state = rnd128();
        req_key   = RT_KEY;
        req_steps = 6'd20;
        req_valid = 1'b1;
        @(posedge g_clk);
        @(negedge g_clk);
        req_valid = 1'b0;
        repeat (6) @(negedge g_clk);
        chk("midrun_busy", {127'd0, busy}, 128'd1);
        g_resetn = 1'b0;
        #1;
        chk("midrun_rst_valid", {127'd0, rsp_valid}, 128'd0);
        chk("midrun_rst_busy", {127'd0, busy}, 128'd0);
        chk("midrun_rst_state", rsp_state, 128'd0);
        @(posedge g_clk);
        @(negedge g_clk);
        g_resetn = 1'b1;
        do_req(vecs[0].st, vecs[0].key, vecs[0].n, 0, 1'b0, res, lat);
        chk("after_rst_state", res, 128'd0);
        chk("after_rst_latency", 128'(lat), 128'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jambu_perm_inv.md
JAMBU_PERM_INV -- requirements
Module: jambu_perm_inv

Interface
REQ-001 SHALL have no parameters. Key length is fixed at 128 bits and the step width is fixed at 32 rounds.
REQ-002 SHALL have the following ports:
- g_clk     input   1    single clock; all state updates on the rising edge
- g_resetn  input   1    asynchronous, active-low reset
- req_valid input   1    request offered
- req_ready output  1    block can accept a request
- req_state input   128  TinyJAMBU state; [31:0]=s0, [63:32]=s1, [95:64]=s2, [127:96]=s3
- req_key   input   128  key; [31:0]=k0 ... [127:96]=k3
- req_steps input   6    N, the number of 32-round steps to invert (0..63)
- rsp_valid output  1    result available
- rsp_ready input   1    consumer accepts the result
- rsp_state output  128  inverted state, same packing as req_state
- busy      output  1    high in RUN or DONE

Function
REQ-003 SHALL implement exactly the inverse of the TinyJAMBU forward step, in which the forward step j is defined as follows:
- t1 = {s2,s1}>>15, t2 = {s3,s2}>>6, t3 = {s3,s2}>>21, t4 = {s3,s2}>>27 (each taking the low 32 bits);
- fb = s0 ^ t1 ^ ~(t2 & t3) ^ t4 ^ k[j mod 4];
- the new state is (s0,s1,s2,s3) = (s1,s2,s3,fb).
REQ-004 SHALL perform one inverse step per cycle, as follows:
- given the current state (a0,a1,a2,a3), compute t1..t4 from (a0,a1,a2) in place of (s1,s2,s3);
- compute s0 = a3 ^ t1 ^ ~(t2 & t3) ^ t4 ^ k[j mod 4];
- the next state is (s0,a0,a1,a2).
REQ-005 SHALL process step indices j = N-1, N-2, ..., 0 in that order, taking the key word index from j[1:0] of a down-counter.
REQ-006 SHALL implement the FSM states IDLE, RUN and DONE with these transitions:
- IDLE to RUN on acceptance when N>0;
- IDLE to DONE on acceptance when N=0;
- RUN to DONE after the step with j=0;
- DONE to IDLE when rsp_ready=1.
REQ-007 SHALL drive req_ready=1 only in IDLE. Acceptance is req_valid & req_ready on a rising edge.
REQ-008 SHALL register req_state, req_key and req_steps at acceptance. Input changes after acceptance have no effect on the result.
REQ-009 SHALL assert rsp_valid exactly N+1 cycles after the acceptance edge (1 cycle for N=0).
REQ-010 SHALL hold rsp_valid and rsp_state stable while rsp_valid=1 and rsp_ready=0, for any number of cycles.
REQ-011 SHALL NOT accept a new request in the cycle the response is consumed. req_ready rises in the cycle after the DONE-to-IDLE transition.
REQ-012 SHALL drive rsp_state to the working state register in all states. Its value is meaningful only while rsp_valid=1.
REQ-013 SHALL return req_state unchanged when N=0.
REQ-014 SHALL ignore rsp_ready outside DONE, and SHALL ignore req_valid outside IDLE.
REQ-015 SHALL keep busy = (state != IDLE) and req_ready = (state == IDLE) mutually exclusive at all times.

Reset
REQ-016 SHALL, on g_resetn=0, immediately (asynchronously) force the following:
- FSM to IDLE;
- step counter, working state and key registers to 0;
- rsp_valid=0, busy=0, rsp_state=0.
REQ-017 SHALL drive req_ready=1 from the first rising edge after g_resetn is deasserted.
REQ-018 SHALL abort any operation in RUN or DONE when reset is asserted. No response is produced for the aborted request, and the next request after reset behaves as if it were the first.

Verification
REQ-019 Single step: state = 128'hFFFFFFFF_00000000_00000000_00000000, key = 0, N=1 -> rsp_state = 0, rsp_valid exactly 2 cycles after acceptance.
REQ-020 Zero steps: state = 128'h0123..CDEF (any pattern), N=0 -> rsp_state equals the input, rsp_valid 1 cycle after acceptance, FSM never enters RUN.
REQ-021 Round trip:
- stimulus: key = 128'h0F0E..0100, state X, forward-apply 20 steps (640 rounds) in the reference model, then issue an inverse request with N=20;
- required response: rsp_state = X, rsp_valid exactly 21 cycles after acceptance;
- repeat with N=32 and N=40 and random X.
REQ-022 Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_valid and rsp_state stay constant, req_ready stays 0; rsp_ready=1 -> rsp_valid falls next cycle and req_ready rises next cycle.
REQ-023 Mid-operation reset: assert g_resetn=0 for 1 cycle at step 7 of an N=20 run -> rsp_valid=0, busy=0, rsp_state=0 immediately; a following N=1 request (REQ-019 vector) gives the correct result.
REQ-024 Input isolation: change req_state, req_key and req_steps every cycle during RUN of an N=20 request -> result identical to REQ-021 for that request.
